mips_mc_control: RTL and testbench
==================================

// Module: mips_mc_control
// PURPOSE
//  Multi-cycle successor to the single-cycle MIPS control unit: one FSM sequences FETCH/DECODE/EXEC/MEM/WB over a shared
//  memory port with req/ready handshake, timeout detection, and JAL/JR support. Sits between IR decode and the datapath.
//  Outputs are Moore (decoded from registered state) except pc_write/ir_write, which qualify on mem_ready/zero.
// PARAMETERS
//  MEM_TIMEOUT  255  max cycles mem_req may wait for mem_ready before fault (1..2**TO_W-1)
//  TO_W         8    width of wait counter
//  CNT_W        32   width of performance counters (MIPS_MC_PERF_EN only)
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      async active-low reset
//  opcode       in   6      IR[31:26], stable from DECODE until next FETCH
//  funct        in   6      IR[5:0]
//  zero         in   1      ALU zero flag (valid in BRANCH)
//  mem_ready    in   1      memory done; sampled while mem_req=1
//  mem_req      out  1      memory request (FETCH, MEM_RD, MEM_WR)
//  mem_we       out  1      write strobe (MEM_WR only)
//  iord         out  1      0=PC address, 1=ALUOut address
//  ir_write     out  1      load IR (FETCH & mem_ready)
//  pc_write     out  1      load PC
//  pc_src       out  2      0=ALU(PC+4) 1=ALUOut(branch) 2=jump target 3=rs (JR)
//  alu_src_a    out  1      0=PC 1=rs
//  alu_src_b    out  2      0=rt 1=const 4 2=sign-ext imm 3=sign-ext imm<<2
//  alu_op       out  2      0=add 1=sub 2=funct-decoded
//  reg_dst      out  2      0=rt 1=rd 2=$ra(31)
//  mem_to_reg   out  2      0=ALUOut 1=MDR 2=PC (link)
//  reg_write    out  1      regfile write enable
//  illegal      out  1      one-cycle pulse: unknown opcode/funct decoded
//  mem_err      out  1      sticky: memory timeout; FSM parked in FAULT
//  state        out  4      current state encoding (debug)
// BEHAVIOUR
//  Reset: state=FETCH(0); wait counter 0; mem_err=0; all other outputs at FETCH-decoded values with mem_ready=0
//   (mem_req=1, alu_src_b=1, pc_src=0, others 0). Reset mid-transaction abandons it; no write strobes during reset.
//  States: 0 FETCH 1 DECODE 2 MEM_ADDR 3 MEM_RD 4 MEM_WB 5 MEM_WR 6 EXEC 7 R_WB 8 BRANCH 9 JUMP 10 JAL 11 JR
//   12 ADDI_EX 13 ADDI_WB 15 FAULT.
//  FETCH: mem_req=1,iord=0,alu_src_a=0,alu_src_b=1,alu_op=0; when mem_ready: ir_write=pc_write=1, ->DECODE.
//  DECODE: alu_src_b=3 (branch target precompute); by opcode: 0x00 funct 0x08->JR, other R->EXEC;
//   0x23/0x2B->MEM_ADDR; 0x04/0x05->BRANCH; 0x02->JUMP; 0x03->JAL; 0x08->ADDI_EX; else illegal=1, ->FETCH.
//  R-type funct in {0x20,0x22,0x24,0x25,0x2A}; any other funct (not 0x08) -> illegal=1, ->FETCH.
//  MEM_ADDR: alu_src_a=1,alu_src_b=2,alu_op=0; lw->MEM_RD, sw->MEM_WR.
//  MEM_RD: mem_req=1,iord=1; mem_ready->MEM_WB. MEM_WB: reg_dst=0,mem_to_reg=1,reg_write=1, ->FETCH.
//  MEM_WR: mem_req=1,mem_we=1,iord=1; mem_ready->FETCH.
//  EXEC: alu_src_a=1,alu_src_b=0,alu_op=2 ->R_WB. R_WB: reg_dst=1,mem_to_reg=0,reg_write=1 ->FETCH.
//  BRANCH: alu_src_a=1,alu_src_b=0,alu_op=1,pc_src=1; pc_write=(beq&zero)|(bne&~zero) ->FETCH.
//  JUMP: pc_src=2,pc_write=1 ->FETCH. JR: pc_src=3,pc_write=1 ->FETCH.
//  JAL: reg_dst=2,mem_to_reg=2,reg_write=1,pc_src=2,pc_write=1 ->FETCH (links PC, already PC+4).
//  ADDI_EX: alu_src_a=1,alu_src_b=2,alu_op=0 ->ADDI_WB. ADDI_WB: reg_dst=0,mem_to_reg=0,reg_write=1 ->FETCH.
//  Latency: lw 5 cycles, sw/R/addi 4, beq/bne/j/jal/jr 3, each plus memory wait cycles.
//  Timeout: wait counter clears on entry to any mem state and when mem_ready=1; increments each cycle mem_req=1 &
//   ~mem_ready; reaching MEM_TIMEOUT -> FAULT, mem_err=1. mem_ready in same cycle as limit wins (no fault).
//  FAULT: all enables/strobes 0, mem_req=0; exits only by reset.
// CONFIGURATION
//  MIPS_MC_PERF_EN defined: adds outputs cycle_cnt[CNT_W], instr_cnt[CNT_W], stall_cnt[CNT_W]; reset to 0;
//   cycle_cnt +1 every non-FAULT cycle; instr_cnt +1 on each transition into FETCH from a non-FETCH state (illegal
//   included); stall_cnt +1 each mem_req&~mem_ready cycle; all wrap modulo 2**CNT_W, freeze in FAULT.
//  Undefined: ports and counters absent; FSM behaviour identical.
// TESTING
//  1 lw (0x23), mem_ready tied 1 -> states 0,1,2,3,4,0; reg_write=1 only in MEM_WB with mem_to_reg=1.
//  2 fetch with mem_ready low 3 cycles -> mem_req held 4 cycles, ir_write/pc_write pulse once on 4th; counter cleared.
//  3 beq zero=1 -> pc_write=1,pc_src=1 in BRANCH; bne zero=1 -> pc_write=0; both return to FETCH after 3 cycles.
//  4 jal (0x03) -> JAL: reg_dst=2,mem_to_reg=2,reg_write=1,pc_write=1,pc_src=2; opcode 0x3F -> illegal pulse, FETCH.
//  5 MEM_TIMEOUT=4, mem_ready held 0 in MEM_RD -> FAULT after 4 wait cycles, mem_err=1 until rst_n=0, then FETCH.
//  6 PERF_EN: run lw,sw,add,j with 0 waits -> instr_cnt=4, cycle_cnt=16; assert rst_n mid-MEM_WR -> counters 0.

Source files
------------

// File: rtl/mips_mc_control.sv
// mips_mc_control: multi-cycle MIPS control FSM.
// Steps FETCH/DECODE/EXEC/MEM/WB over one shared memory port that uses a req/ready handshake.
// Supports JAL and JR. Detects memory timeouts and parks the FSM in FAULT until reset.
// Outputs are decoded from the registered state (Moore), with three exceptions:
// ir_write and pc_write also qualify on mem_ready/zero, and illegal depends on the IR fields.
//
// Parameters: MEM_TIMEOUT (wait limit), TO_W (wait counter width), CNT_W (perf counter width)
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   opcode, funct, zero         IR fields and ALU zero flag
//   mem_ready                   memory handshake done
//   mem_req, mem_we, iord       memory request, write strobe, address select
//   ir_write, pc_write, pc_src  IR/PC load controls
//   alu_src_a/b, alu_op         ALU operand and operation selects
//   reg_dst, mem_to_reg         regfile write address/data selects
//   reg_write                   regfile write enable
//   illegal                     one-cycle pulse on an undecodable instruction
//   mem_err                     sticky memory timeout indication
//   state                       current state (debug)
// Optional feature macro MIPS_MC_PERF_EN adds three counters:
//   cycle_cnt, instr_cnt, stall_cnt.
module mips_mc_control #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TO_W        = 8,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             reg_write,
  output logic             illegal,
  output logic             mem_err,
`ifdef MIPS_MC_PERF_EN
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] stall_cnt,
`endif
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAddr = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExec    = 4'd6,
    StRWb     = 4'd7,
    StBranch  = 4'd8,
    StJump    = 4'd9,
    StJal     = 4'd10,
    StJr      = 4'd11,
    StAddiEx  = 4'd12,
    StAddiWb  = 4'd13,
    StFault   = 4'd15
  } state_e;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] FnJr    = 6'h08;

  state_e          state_q, state_d;
  logic [TO_W-1:0] wait_q, wait_d;
  state_e          dec_target;
  logic            dec_illegal;
  logic            stall;
  logic            timeout_hit;

  // Only FETCH, MEM_RD and MEM_WR raise mem_req, so a stall is a waiting memory state.
  assign stall       = (state_q == StFetch || state_q == StMemRd || state_q == StMemWr) &&
                       !mem_ready;
  // This is the MEM_TIMEOUT-th waiting cycle; a mem_ready in the same cycle clears stall and wins.
  assign timeout_hit = stall && (wait_q == TO_W'(MEM_TIMEOUT - 1));

  // Instruction decode, used only in DECODE.
  always_comb begin
    dec_target  = StFetch;
    dec_illegal = 1'b0;
    case (opcode)
      OpRtype: begin
        if (funct == FnJr) begin
          dec_target = StJr;
        end else if (funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) begin
          dec_target = StExec;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OpLw, OpSw:   dec_target = StMemAddr;
      OpBeq, OpBne: dec_target = StBranch;
      OpJ:          dec_target = StJump;
      OpJal:        dec_target = StJal;
      OpAddi:       dec_target = StAddiEx;
      default:      dec_illegal = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch: begin
        if (mem_ready)        state_d = StDecode;
        else if (timeout_hit) state_d = StFault;
      end
      StDecode:  state_d = dec_target;
      StMemAddr: state_d = (opcode == OpLw) ? StMemRd : StMemWr;
      StMemRd: begin
        if (mem_ready)        state_d = StMemWb;
        else if (timeout_hit) state_d = StFault;
      end
      StMemWr: begin
        if (mem_ready)        state_d = StFetch;
        else if (timeout_hit) state_d = StFault;
      end
      StExec:   state_d = StRWb;
      StAddiEx: state_d = StAddiWb;
      StMemWb, StRWb, StBranch, StJump, StJal, StJr, StAddiWb: state_d = StFetch;
      StFault:  state_d = StFault;
      default:  state_d = StFetch;
    endcase
    // The counter restarts whenever the state changes (entry to a memory state included) or ready is seen.
    wait_d = (stall && state_d == state_q) ? wait_q + 1'b1 : '0;
  end

  // Output decode.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'd0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_op     = 2'd0;
    reg_dst    = 2'd0;
    mem_to_reg = 2'd0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      StFetch: begin
        mem_req   = 1'b1;
        alu_src_b = 2'd1;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      StDecode: begin
        alu_src_b = 2'd3;
        illegal   = dec_illegal;
      end
      StMemAddr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
      end
      StMemRd: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      StMemWb: begin
        mem_to_reg = 2'd1;
        reg_write  = 1'b1;
      end
      StMemWr: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
      end
      StExec: begin
        alu_src_a = 1'b1;
        alu_op    = 2'd2;
      end
      StRWb: begin
        reg_dst   = 2'd1;
        reg_write = 1'b1;
      end
      StBranch: begin
        alu_src_a = 1'b1;
        alu_op    = 2'd1;
        pc_src    = 2'd1;
        pc_write  = (opcode == OpBeq && zero) || (opcode == OpBne && !zero);
      end
      StJump: begin
        pc_src   = 2'd2;
        pc_write = 1'b1;
      end
      StJal: begin
        reg_dst    = 2'd2;
        mem_to_reg = 2'd2;
        reg_write  = 1'b1;
        pc_src     = 2'd2;
        pc_write   = 1'b1;
      end
      StJr: begin
        pc_src   = 2'd3;
        pc_write = 1'b1;
      end
      StAddiEx: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
      end
      StAddiWb: reg_write = 1'b1;
      default: ;
    endcase
  end

  assign mem_err = (state_q == StFault);
  assign state   = state_q;

`ifdef MIPS_MC_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
      stall_cnt <= '0;
    end else if (state_q != StFault) begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (state_d == StFetch && state_q != StFetch) instr_cnt <= instr_cnt + 1'b1;
      if (stall) stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_mc_control.sv
module tb_mips_mc_control;

  typedef struct packed {
    logic [3:0] st;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       illegal;
    logic       mem_err;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h20;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, iord, ir_write, pc_write, alu_src_a, reg_write, illegal, mem_err;
  logic [1:0] pc_src, alu_src_b, alu_op, reg_dst, mem_to_reg;
  logic [3:0] state;
`ifdef MIPS_MC_PERF_EN
  logic [31:0] cycle_cnt, instr_cnt, stall_cnt;
`endif

  int   n_vec = 0;
  int   n_err = 0;
  vec_t sb[$];
  vec_t obs;

  always #5 clk = ~clk;

  mips_mc_control #(
    .MEM_TIMEOUT(4),
    .TO_W       (8),
    .CNT_W      (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opcode    (opcode),
    .funct     (funct),
    .zero      (zero),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .iord      (iord),
    .ir_write  (ir_write),
    .pc_write  (pc_write),
    .pc_src    (pc_src),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .alu_op    (alu_op),
    .reg_dst   (reg_dst),
    .mem_to_reg(mem_to_reg),
    .reg_write (reg_write),
    .illegal   (illegal),
    .mem_err   (mem_err),
`ifdef MIPS_MC_PERF_EN
    .cycle_cnt (cycle_cnt),
    .instr_cnt (instr_cnt),
    .stall_cnt (stall_cnt),
`endif
    .state     (state)
  );

  assign obs = '{state, mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
                 alu_op, reg_dst, mem_to_reg, reg_write, illegal, mem_err};

  // Expected control word for a given state, straight from the per-state output table.
  function automatic vec_t expect_for(input logic [3:0] st, input logic rdy, input logic z,
                                      input logic [5:0] opc, input logic [5:0] fn);
    vec_t e;
    e    = '0;
    e.st = st;
    case (st)
      4'd0: begin e.mem_req = 1; e.alu_src_b = 1; e.ir_write = rdy; e.pc_write = rdy; end
      4'd1: begin
        e.alu_src_b = 3;
        if (opc == 6'h00)
          e.illegal = !(fn == 6'h08 || fn == 6'h20 || fn == 6'h22 || fn == 6'h24 ||
                        fn == 6'h25 || fn == 6'h2A);
        else
          e.illegal = !(opc == 6'h23 || opc == 6'h2B || opc == 6'h04 || opc == 6'h05 ||
                        opc == 6'h02 || opc == 6'h03 || opc == 6'h08);
      end
      4'd2: begin e.alu_src_a = 1; e.alu_src_b = 2; end
      4'd3: begin e.mem_req = 1; e.iord = 1; end
      4'd4: begin e.mem_to_reg = 1; e.reg_write = 1; end
      4'd5: begin e.mem_req = 1; e.mem_we = 1; e.iord = 1; end
      4'd6: begin e.alu_src_a = 1; e.alu_op = 2; end
      4'd7: begin e.reg_dst = 1; e.reg_write = 1; end
      4'd8: begin
        e.alu_src_a = 1; e.alu_op = 1; e.pc_src = 1;
        e.pc_write = (opc == 6'h04 && z) || (opc == 6'h05 && !z);
      end
      4'd9:  begin e.pc_src = 2; e.pc_write = 1; end
      4'd10: begin e.reg_dst = 2; e.mem_to_reg = 2; e.reg_write = 1; e.pc_src = 2; e.pc_write = 1; end
      4'd11: begin e.pc_src = 3; e.pc_write = 1; end
      4'd12: begin e.alu_src_a = 1; e.alu_src_b = 2; end
      4'd13: e.reg_write = 1;
      4'd15: e.mem_err = 1;
      default: ;
    endcase
    return e;
  endfunction

  // One clock cycle: drive inputs, queue the expectation, compare at the falling edge.
  task automatic step(input string tag, input logic [3:0] st, input logic rdy, input logic z,
                      input logic [5:0] opc, input logic [5:0] fn);
    vec_t e;
    mem_ready = rdy;
    zero      = z;
    opcode    = opc;
    funct     = fn;
    sb.push_back(expect_for(st, rdy, z, opc, fn));
    @(negedge clk);
    e = sb.pop_front();
    n_vec++;
    assert (obs === e) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
    end
    @(posedge clk);
    #1;
  endtask

`ifdef MIPS_MC_PERF_EN
  task automatic chk_cnt(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, want);
    end
  endtask
`endif

  initial begin
    // Reset state: FETCH outputs with mem_ready low.
    @(posedge clk);
    #1;
    step("reset", 4'd0, 1'b0, 1'b0, 6'h00, 6'h00);
    rst_n = 1'b1;

    // lw, no waits: 0,1,2,3,4.
    step("lw_fetch", 4'd0, 1, 0, 6'h23, 6'h00);
    step("lw_dec",   4'd1, 1, 0, 6'h23, 6'h00);
    step("lw_addr",  4'd2, 1, 0, 6'h23, 6'h00);
    step("lw_rd",    4'd3, 1, 0, 6'h23, 6'h00);
    step("lw_wb",    4'd4, 1, 0, 6'h23, 6'h00);

    // Fetch stalls 3 cycles then an add R-type.
    step("stall_1",  4'd0, 0, 0, 6'h00, 6'h20);
    step("stall_2",  4'd0, 0, 0, 6'h00, 6'h20);
    step("stall_3",  4'd0, 0, 0, 6'h00, 6'h20);
    step("stall_4",  4'd0, 1, 0, 6'h00, 6'h20);
    step("add_dec",  4'd1, 1, 0, 6'h00, 6'h20);
    step("add_exec", 4'd6, 1, 0, 6'h00, 6'h20);
    step("add_wb",   4'd7, 1, 0, 6'h00, 6'h20);

    // beq taken, bne not taken (both with zero=1).
    step("beq_fetch", 4'd0, 1, 0, 6'h04, 6'h00);
    step("beq_dec",   4'd1, 1, 0, 6'h04, 6'h00);
    step("beq_br",    4'd8, 1, 1, 6'h04, 6'h00);
    step("bne_fetch", 4'd0, 1, 0, 6'h05, 6'h00);
    step("bne_dec",   4'd1, 1, 0, 6'h05, 6'h00);
    step("bne_br",    4'd8, 1, 1, 6'h05, 6'h00);

    // jal, jr, j, addi.
    step("jal_fetch", 4'd0,  1, 0, 6'h03, 6'h00);
    step("jal_dec",   4'd1,  1, 0, 6'h03, 6'h00);
    step("jal_ex",    4'd10, 1, 0, 6'h03, 6'h00);
    step("jr_fetch",  4'd0,  1, 0, 6'h00, 6'h08);
    step("jr_dec",    4'd1,  1, 0, 6'h00, 6'h08);
    step("jr_ex",     4'd11, 1, 0, 6'h00, 6'h08);
    step("j_fetch",   4'd0,  1, 0, 6'h02, 6'h00);
    step("j_dec",     4'd1,  1, 0, 6'h02, 6'h00);
    step("j_ex",      4'd9,  1, 0, 6'h02, 6'h00);
    step("addi_fetch", 4'd0,  1, 0, 6'h08, 6'h00);
    step("addi_dec",   4'd1,  1, 0, 6'h08, 6'h00);
    step("addi_ex",    4'd12, 1, 0, 6'h08, 6'h00);
    step("addi_wb",    4'd13, 1, 0, 6'h08, 6'h00);

    // Illegal opcode and illegal funct both pulse illegal and return to FETCH.
    step("ill_op_fetch", 4'd0, 1, 0, 6'h3F, 6'h00);
    step("ill_op_dec",   4'd1, 1, 0, 6'h3F, 6'h00);
    step("ill_fn_fetch", 4'd0, 1, 0, 6'h00, 6'h3F);
    step("ill_fn_dec",   4'd1, 1, 0, 6'h00, 6'h3F);

    // sw with ready arriving on the limit cycle: no fault.
    step("sw_fetch", 4'd0, 1, 0, 6'h2B, 6'h00);
    step("sw_dec",   4'd1, 1, 0, 6'h2B, 6'h00);
    step("sw_addr",  4'd2, 1, 0, 6'h2B, 6'h00);
    step("sw_wait1", 4'd5, 0, 0, 6'h2B, 6'h00);
    step("sw_wait2", 4'd5, 0, 0, 6'h2B, 6'h00);
    step("sw_wait3", 4'd5, 0, 0, 6'h2B, 6'h00);
    step("sw_limit", 4'd5, 1, 0, 6'h2B, 6'h00);

    // lw with memory never ready: FAULT after 4 waiting cycles, sticky until reset.
    step("to_fetch", 4'd0, 1, 0, 6'h23, 6'h00);
    step("to_dec",   4'd1, 1, 0, 6'h23, 6'h00);
    step("to_addr",  4'd2, 1, 0, 6'h23, 6'h00);
    step("to_wait1", 4'd3, 0, 0, 6'h23, 6'h00);
    step("to_wait2", 4'd3, 0, 0, 6'h23, 6'h00);
    step("to_wait3", 4'd3, 0, 0, 6'h23, 6'h00);
    step("to_wait4", 4'd3, 0, 0, 6'h23, 6'h00);
    step("fault_1",  4'd15, 0, 0, 6'h23, 6'h00);
    step("fault_2",  4'd15, 1, 0, 6'h23, 6'h00);
    rst_n = 1'b0;
    step("fault_rst", 4'd0, 1'b0, 0, 6'h00, 6'h00);
    rst_n = 1'b1;

`ifdef MIPS_MC_PERF_EN
    chk_cnt("perf_rst_cycle", cycle_cnt, 32'd0);
    // lw, sw, add, j with no waits: 5+4+4+3 cycles, 4 instructions.
    step("p_lw0", 4'd0, 1, 0, 6'h23, 6'h00);
    step("p_lw1", 4'd1, 1, 0, 6'h23, 6'h00);
    step("p_lw2", 4'd2, 1, 0, 6'h23, 6'h00);
    step("p_lw3", 4'd3, 1, 0, 6'h23, 6'h00);
    step("p_lw4", 4'd4, 1, 0, 6'h23, 6'h00);
    step("p_sw0", 4'd0, 1, 0, 6'h2B, 6'h00);
    step("p_sw1", 4'd1, 1, 0, 6'h2B, 6'h00);
    step("p_sw2", 4'd2, 1, 0, 6'h2B, 6'h00);
    step("p_sw3", 4'd5, 1, 0, 6'h2B, 6'h00);
    step("p_ad0", 4'd0, 1, 0, 6'h00, 6'h22);
    step("p_ad1", 4'd1, 1, 0, 6'h00, 6'h22);
    step("p_ad2", 4'd6, 1, 0, 6'h00, 6'h22);
    step("p_ad3", 4'd7, 1, 0, 6'h00, 6'h22);
    step("p_j0",  4'd0, 1, 0, 6'h02, 6'h00);
    step("p_j1",  4'd1, 1, 0, 6'h02, 6'h00);
    step("p_j2",  4'd9, 1, 0, 6'h02, 6'h00);
    chk_cnt("perf_instr", instr_cnt, 32'd4);
    chk_cnt("perf_cycle", cycle_cnt, 32'd16);
    chk_cnt("perf_stall", stall_cnt, 32'd0);
    // Stall twice in MEM_WR, then reset mid-transaction.
    step("p_sw4", 4'd0, 1, 0, 6'h2B, 6'h00);
    step("p_sw5", 4'd1, 1, 0, 6'h2B, 6'h00);
    step("p_sw6", 4'd2, 1, 0, 6'h2B, 6'h00);
    step("p_sw7", 4'd5, 0, 0, 6'h2B, 6'h00);
    step("p_sw8", 4'd5, 0, 0, 6'h2B, 6'h00);
    chk_cnt("perf_stall2", stall_cnt, 32'd2);
    rst_n = 1'b0;
    #1;
    chk_cnt("perf_rst_c", cycle_cnt, 32'd0);
    chk_cnt("perf_rst_i", instr_cnt, 32'd0);
    chk_cnt("perf_rst_s", stall_cnt, 32'd0);
    step("p_rst", 4'd0, 1'b0, 0, 6'h00, 6'h00);
    rst_n = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
